alu_cmd_issuer: RTL and testbench

//   Upstream feeder for the 4-bit ALU (synth_wrapper). Buffers {op,a,b} commands from a

---
 rtl/alu_issuer_pkg.sv | 19 +
 rtl/alu_cmd_fifo.sv | 60 ++++++
 rtl/alu_cmd_issuer.sv | 145 ++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issuer_pkg.sv
// Shared types for the ALU command issuer: FSM state encoding and default command layout.
package alu_issuer_pkg;

  localparam int unsigned ISSUER_DATA_W = 4;
  localparam int unsigned ISSUER_OP_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } issuer_state_e;

  typedef struct packed {
    logic [ISSUER_OP_W-1:0]   op;
    logic [ISSUER_DATA_W-1:0] a;
    logic [ISSUER_DATA_W-1:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries of a packed command type, occupancy counter, async active-low reset.
module alu_cmd_fifo
  import alu_issuer_pkg::*;
#(
  parameter type         T     = alu_cmd_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  T     wdata_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Feeds buffered {op,a,b} commands to a fixed-latency ALU one at a time and returns results in order.
// Optional ALU_ISSUER_STATS_EN adds an 8-bit response handshake counter port (rsp_count).
module alu_cmd_issuer
  import alu_issuer_pkg::*;
#(
  parameter int unsigned DATA_W  = ISSUER_DATA_W,
  parameter int unsigned OP_W    = ISSUER_OP_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic [OP_W-1:0]   rsp_op,
  output logic              busy
`ifdef ALU_ISSUER_STATS_EN
  ,
  output logic [7:0]        rsp_count
`endif
);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  localparam logic [1:0] LAT_CNT = 2'(ALU_LAT);

  cmd_t              cmd_in;
  cmd_t              fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  issuer_state_e     state_q;
  logic [1:0]        cnt_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_carry_q;
  logic [OP_W-1:0]   rsp_op_q;

  assign cmd_in   = {cmd_op, cmd_a, cmd_b};
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  alu_cmd_fifo #(
    .T     (cmd_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid),
    .pop_i   (fifo_pop),
    .wdata_i (cmd_in),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The issue step shares the IDLE pop edge, so the ALU sees operands one cycle after the pop decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_op_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            alu_a_q  <= fifo_head.a;
            alu_b_q  <= fifo_head.b;
            alu_op_q <= fifo_head.op;
            cnt_q    <= LAT_CNT;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 2'd1;
          end else begin
            rsp_result_q <= alu_result;
            rsp_carry_q  <= alu_carry;
            rsp_op_q     <= alu_op_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = !fifo_full;
  assign busy       = !fifo_empty || (state_q != IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_op     = rsp_op_q;

`ifdef ALU_ISSUER_STATS_EN
  logic [7:0] rsp_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_count_q <= '0;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_count_q <= rsp_count_q + 8'd1;
    end
  end

  assign rsp_count = rsp_count_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed plus randomized bench for alu_cmd_issuer with a registered (1-cycle) ALU model.
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic [2:0] rsp_op;
  logic       busy;
`ifdef ALU_ISSUER_STATS_EN
  logic [7:0] rsp_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_issuer #(
    .DATA_W  (4),
    .OP_W    (3),
    .DEPTH   (4),
    .ALU_LAT (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_op     (rsp_op),
    .busy       (busy)
`ifdef ALU_ISSUER_STATS_EN
    ,
    .rsp_count  (rsp_count)
`endif
  );

  // ALU behaviour: {carry, result}; op 0 is a+b with carry out.
  function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {(a < b), 4'(a - b)};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {a[3], a[2:0], 1'b0};
      3'd6:    return {a[0], 1'b0, a[3:1]};
      default: return {1'b0, ~a};
    endcase
  endfunction

  always @(posedge clk) {alu_carry, alu_result} <= alu_ref(alu_op, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes visible before the edge, then advance to #1 after it.
  task automatic step();
    logic       pushed, popped, held;
    logic [3:0] s_res;
    logic       s_c;
    logic [2:0] s_op;
    logic [4:0] e;
    pushed = cmd_valid && cmd_ready;
    popped = rsp_valid && rsp_ready;
    held   = rsp_valid && !rsp_ready;
    s_res  = rsp_result;
    s_c    = rsp_carry;
    s_op   = rsp_op;
    if (popped) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(1), 32'(0));
      end else begin
        e = alu_ref(exp_q[0][10:8], exp_q[0][7:4], exp_q[0][3:0]);
        check("rsp_result", 32'(rsp_result), 32'(e[3:0]));
        check("rsp_carry", 32'(rsp_carry), 32'(e[4]));
        check("rsp_op", 32'(rsp_op), 32'(exp_q[0][10:8]));
        void'(exp_q.pop_front());
        n_hs++;
      end
    end
    if (pushed) exp_q.push_back({cmd_op, cmd_a, cmd_b});
    @(posedge clk);
    #1;
    if (held) begin
      check("rsp_hold_valid", 32'(rsp_valid), 32'(1));
      check("rsp_hold_data", 32'({rsp_op, rsp_carry, rsp_result}), 32'({s_op, s_c, s_res}));
    end
  endtask

  task automatic single(input logic [3:0] a, input logic [3:0] b, input logic [3:0] res, input logic c);
    cmd_a = a; cmd_b = b; cmd_op = 3'd0; cmd_valid = 1'b1;
    check("single_cmd_ready", 32'(cmd_ready), 32'(1));
    step();
    cmd_valid = 1'b0;
    check("single_busy", 32'(busy), 32'(1));
    check("single_t0_rsp_valid", 32'(rsp_valid), 32'(0));
    step();
    check("single_alu_a", 32'(alu_a), 32'(a));
    check("single_alu_b", 32'(alu_b), 32'(b));
    check("single_alu_op", 32'(alu_op), 32'(0));
    check("single_t1_rsp_valid", 32'(rsp_valid), 32'(0));
    step();
    check("single_t2_rsp_valid", 32'(rsp_valid), 32'(0));
    step();
    check("single_t3_rsp_valid", 32'(rsp_valid), 32'(1));
    check("single_rsp_result", 32'(rsp_result), 32'(res));
    check("single_rsp_carry", 32'(rsp_carry), 32'(c));
    check("single_rsp_op", 32'(rsp_op), 32'(0));
    rsp_ready = 1'b1;
    step();
    check("single_done_valid", 32'(rsp_valid), 32'(0));
    check("single_done_busy", 32'(busy), 32'(0));
    rsp_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || busy); i++) step();
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    rsp_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_alu"}, 32'({alu_op, alu_a, alu_b}), 32'(0));
    check({tag, "_rsp"}, 32'({rsp_valid, rsp_op, rsp_carry, rsp_result}), 32'(0));
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
    check({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int rv_seen;
    logic [11:0] snap;

    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_held");
`ifdef ALU_ISSUER_STATS_EN
    check("reset_rsp_count", 32'(rsp_count), 32'(0));
`endif
    rst_n = 1'b1;
    step();
    check_idle_outputs("reset_released");

    single(4'd5, 4'd10, 4'hF, 1'b0);
    single(4'd15, 4'd2, 4'h1, 1'b1);

    // Five commands back-to-back with the consumer stalled.
    for (int k = 0; k < 5; k++) begin
      cmd_valid = 1'b1;
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
      check("b2b_accept", 32'(cmd_ready), 32'(1));
      step();
    end
    cmd_valid = 1'b0;
    check("b2b_full_cmd_ready", 32'(cmd_ready), 32'(0));
    check("b2b_busy", 32'(busy), 32'(1));
    check("b2b_rsp_valid", 32'(rsp_valid), 32'(1));
    snap = {rsp_valid, rsp_op, rsp_carry, rsp_result, 3'b0};
    repeat (10) step();
    check("b2b_hold_snapshot", 32'({rsp_valid, rsp_op, rsp_carry, rsp_result, 3'b0}), 32'(snap));
    check("b2b_hold_cmd_ready", 32'(cmd_ready), 32'(0));
    drain("b2b_drain");

    // Reset asserted while the command is waiting on the ALU.
    cmd_a = 4'd3; cmd_b = 4'd4; cmd_op = 3'd0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midwait_reset");
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid) rv_seen++;
    end
    check("midwait_rsp_never", 32'(rv_seen), 32'(0));
    check("midwait_cmd_ready", 32'(cmd_ready), 32'(1));
    check("midwait_busy", 32'(busy), 32'(0));

    // Random traffic against the in-order reference queue.
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 9) < 6);
      rsp_ready = ($urandom_range(0, 1) == 1);
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
      step();
    end
    drain("rand_drain");

`ifdef ALU_ISSUER_STATS_EN
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("stats_reset_count", 32'(rsp_count), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_hs = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3000 && n_hs < 300; i++) begin
      cmd_valid = 1'b1;
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
      step();
    end
    check("stats_handshakes", 32'(n_hs), 32'(300));
    check("stats_rsp_count", 32'(rsp_count), 32'(44));
    drain("stats_drain");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
